// File: rtl/hist_pkg.sv
// Shared types, default sizing and bin decode for the histogram register file.
package hist_pkg;

  localparam int unsigned DEF_NUM_REGS = 64;
  localparam int unsigned DEF_LANES    = 4;
  localparam int unsigned DEF_LANE_W   = 16;
  localparam int unsigned DEF_SAMPLE_W = 8;
  localparam int unsigned DEF_SAMPLES  = 8;

  localparam int unsigned BIN_REG_W  = $clog2(DEF_NUM_REGS);
  localparam int unsigned BIN_LANE_W = $clog2(DEF_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [BIN_LANE_W-1:0] lane_idx;
    logic [BIN_REG_W-1:0]  reg_idx;
  } bin_t;

  // Low bits select the register, top bits select the lane inside it.
  function automatic bin_t decode_bin(input logic [DEF_SAMPLE_W-1:0] sample);
    bin_t b;
    b.reg_idx  = sample[BIN_REG_W-1:0];
    b.lane_idx = sample[DEF_SAMPLE_W-1 -: BIN_LANE_W];
    return b;
  endfunction

endpackage

// File: rtl/hist_sat_inc.sv
// Combinational saturating +1 for one histogram counter.
module hist_sat_inc #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] cnt_in,
  output logic [W-1:0] cnt_c,
  output logic         sat_c
);

  always_comb begin
    sat_c = &cnt_in;
    cnt_c = sat_c ? cnt_in : cnt_in + W'(1);
  end

endmodule

// File: rtl/hist_regfile_accum.sv
// Histogram register file with serialised in-place accumulate and clear sweep.
// Optional sticky saturation flag output enabled by HIST_SAT_FLAG_EN.
module hist_regfile_accum
  import hist_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned LANE_W   = DEF_LANE_W,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned SAMPLES  = DEF_SAMPLES,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  localparam int unsigned WORD_W  = LANES * LANE_W,
  localparam int unsigned BEAT_W  = SAMPLES * SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_gather,
  input  logic [BEAT_W-1:0] rd_idx,
  output logic [WORD_W-1:0] rd_data,
  input  logic              accum_valid,
  output logic              accum_ready,
  input  logic [BEAT_W-1:0] accum_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
`ifdef HIST_SAT_FLAG_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int unsigned SLOT_AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [REG_AW-1:0]  LAST_REG  = REG_AW'(NUM_REGS - 1);
  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(SAMPLES - 1);

  if (NUM_REGS * LANES != 2 ** SAMPLE_W) begin : g_bad_bins
    $error("NUM_REGS*LANES must equal 2**SAMPLE_W");
  end
  if (SAMPLES * SAMPLE_W != LANES * LANE_W) begin : g_bad_gather
    $error("gather read needs SAMPLES*SAMPLE_W == LANES*LANE_W");
  end
  if (NUM_REGS != DEF_NUM_REGS || LANES != DEF_LANES || SAMPLE_W != DEF_SAMPLE_W) begin : g_bad_bin_t
    $error("bin_t in hist_pkg is sized for the default register/lane geometry");
  end

  logic [WORD_W-1:0]  mem_q [NUM_REGS];
  state_e             state_q, state_d;
  logic [REG_AW-1:0]  clr_idx_q, clr_idx_d;
  logic [SLOT_AW-1:0] slot_q, slot_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_drop_q, wr_drop_d;
  logic [WORD_W-1:0]  rd_data_q, rd_data_d;
  logic               sat_flag_q, sat_flag_d;

  logic               mem_we;
  logic [REG_AW-1:0]  mem_waddr;
  logic [WORD_W-1:0]  mem_wdata;

  bin_t               acc_bin;
  logic [WORD_W-1:0]  acc_word;
  logic [LANE_W-1:0]  acc_cnt, acc_inc;
  logic               acc_sat;

  bin_t               g_bin;
  logic [WORD_W-1:0]  g_word;

  // Read side of the single accumulate read-modify-write path.
  always_comb begin
    acc_bin  = decode_bin(beat_q[slot_q*SAMPLE_W +: SAMPLE_W]);
    acc_word = mem_q[acc_bin.reg_idx];
    acc_cnt  = acc_word[acc_bin.lane_idx*LANE_W +: LANE_W];
  end

  hist_sat_inc #(.W(LANE_W)) u_sat_inc (
    .cnt_in (acc_cnt),
    .cnt_c  (acc_inc),
    .sat_c  (acc_sat)
  );

  // Next state, memory write port and ready.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    slot_d      = slot_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    wr_drop_d   = 1'b0;
    sat_flag_d  = sat_flag_q;
    accum_ready = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;

    unique case (state_q)
      IDLE: begin
        accum_ready = !clr_start;
        mem_we      = wr_en;
        if (clr_start) begin
          state_d    = CLEAR;
          clr_idx_d  = '0;
          sat_flag_d = 1'b0;
        end else if (accum_valid) begin
          state_d = ACCUM;
          slot_d  = '0;
          beat_d  = accum_data;
        end
      end
      ACCUM: begin
        wr_drop_d = wr_en;
        // A saturated counter keeps its value, so the write can be skipped.
        mem_we    = !acc_sat;
        mem_waddr = acc_bin.reg_idx;
        mem_wdata = acc_word;
        mem_wdata[acc_bin.lane_idx*LANE_W +: LANE_W] = acc_inc;
        if (acc_sat) begin
          sat_flag_d = 1'b1;
        end
        slot_d = slot_q + 1'b1;
        if (slot_q == LAST_SLOT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      CLEAR: begin
        wr_drop_d = wr_en;
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_REG) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Full or gather read, sampled against pre-write memory contents.
  always_comb begin
    g_bin     = '0;
    g_word    = '0;
    rd_data_d = mem_q[rd_addr];
    if (rd_gather) begin
      for (int s = 0; s < int'(SAMPLES); s++) begin
        g_bin  = decode_bin(rd_idx[s*SAMPLE_W +: SAMPLE_W]);
        g_word = mem_q[g_bin.reg_idx];
        rd_data_d[s*SAMPLE_W +: SAMPLE_W] = g_word[g_bin.lane_idx*LANE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      slot_q     <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      wr_drop_q  <= 1'b0;
      rd_data_q  <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      slot_q     <= slot_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_drop_q  <= wr_drop_d;
      rd_data_q  <= rd_data_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  // Counter storage is not reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_drop = wr_drop_q;
`ifdef HIST_SAT_FLAG_EN
  assign sat_flag = sat_flag_q;
`endif

endmodule

// File: tb/tb_hist_regfile_accum.sv
// Self-checking bench: directed scenarios plus random traffic against an op-queue histogram model.
module tb_hist_regfile_accum;

  localparam int unsigned NR = 64;
  localparam int unsigned NL = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned SW = 8;
  localparam int unsigned NS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [5:0]  rd_addr = '0;
  logic        rd_gather = 1'b0;
  logic [63:0] rd_idx = '0;
  logic [63:0] rd_data;
  logic        accum_valid = 1'b0;
  logic        accum_ready;
  logic [63:0] accum_data = '0;
  logic        clr_start = 1'b0;
  logic        busy, done, wr_drop;
`ifdef HIST_SAT_FLAG_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  hist_regfile_accum dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_gather(rd_gather), .rd_idx(rd_idx), .rd_data(rd_data),
    .accum_valid(accum_valid), .accum_ready(accum_ready), .accum_data(accum_data),
    .clr_start(clr_start), .busy(busy), .done(done), .wr_drop(wr_drop)
`ifdef HIST_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counters as an array, pending work as a queue of single-cycle ops.
  // op < 256 increments bin op; op >= 256 zeroes register op-256.
  logic [15:0] mm [NR][NL];
  int unsigned opq[$];
  logic        m_busy, m_done, m_drop, m_sat, m_rd_ok, m_known;
  logic [63:0] m_rd;

  function automatic logic [63:0] model_read(input logic [5:0] a, input logic g, input logic [63:0] idx);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    if (!g) begin
      for (int l = 0; l < int'(NL); l++) r[l*LW +: LW] = mm[a][l];
    end else begin
      for (int s = 0; s < int'(NS); s++) begin
        b = idx[s*SW +: SW];
        r[s*SW +: SW] = mm[int'(b) % NR][int'(b) / NR][7:0];
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int unsigned op;
    if (!rst_n) begin
      opq.delete();
      for (int i = 0; i < int'(NR); i++) opq.push_back(256 + i);
      m_busy = 1'b1; m_done = 1'b0; m_drop = 1'b0; m_sat = 1'b0;
      m_rd = '0; m_rd_ok = 1'b1; m_known = 1'b0;
    end else begin
      m_done  = 1'b0;
      m_drop  = 1'b0;
      m_rd    = model_read(rd_addr, rd_gather, rd_idx);
      m_rd_ok = m_known;
      if (opq.size() == 0) begin
        if (wr_en) for (int l = 0; l < int'(NL); l++) mm[wr_addr][l] = wr_data[l*LW +: LW];
        if (clr_start) begin
          for (int i = 0; i < int'(NR); i++) opq.push_back(256 + i);
          m_sat = 1'b0;
        end else if (accum_valid) begin
          for (int s = 0; s < int'(NS); s++) opq.push_back(int'(accum_data[s*SW +: SW]));
        end
      end else begin
        m_drop = wr_en;
        op = opq.pop_front();
        if (op >= 256) begin
          for (int l = 0; l < int'(NL); l++) mm[op-256][l] = '0;
        end else if (mm[op % NR][op / NR] == 16'hFFFF) begin
          m_sat = 1'b1;
        end else begin
          mm[op % NR][op / NR] = mm[op % NR][op / NR] + 16'd1;
        end
        if (opq.size() == 0) begin
          m_done  = 1'b1;
          m_known = 1'b1;
        end
      end
      m_busy = (opq.size() != 0);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("wr_drop", wr_drop, m_drop);
    check("accum_ready", accum_ready, (opq.size() == 0) && !clr_start && rst_n);
    if (m_rd_ok) check("rd_data", rd_data, m_rd);
`ifdef HIST_SAT_FLAG_EN
    check("sat_flag", sat_flag, m_sat);
`endif
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 300);
    if (busy) check({name, "_timeout"}, busy, 1'b0);
  endtask

  task automatic beat(input logic [63:0] d, output int n);
    accum_valid = 1'b1;
    accum_data  = d;
    n = 0;
    tick();
    n++;
    accum_valid = 1'b0;
    wr_en = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) check("beat_done_timeout", done, 1'b1);
  endtask

  task automatic read_full(input logic [5:0] a, input string name, input logic [63:0] exp);
    rd_gather = 1'b0;
    rd_addr = a;
    tick();
    check(name, rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle("reset_clear", n);
    check("reset_clear_len", 64'(n), 64'd64);
    for (int r = 0; r < int'(NR); r++) read_full(6'(r), "init_zero", 64'd0);

    beat(64'h0303_0303_0303_0303, n);
    check("done_latency", 64'(n - 1), 64'd8);
    read_full(6'd3, "reg3_dup8", 64'h0000_0000_0000_0008);

    beat(64'hC181_4101_C181_4101, n);
    read_full(6'd1, "reg1_lanes2", 64'h0002_0002_0002_0002);

    // Dropped write during ACCUM, then gather read.
    accum_valid = 1'b1;
    accum_data  = 64'h0101_0101_0101_0101;
    tick();
    accum_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = '1;
    tick();
    wr_en = 1'b0;
    check("wr_drop_pulse", wr_drop, 1'b1);
    wait_idle("accum_drop", n);
    read_full(6'd3, "reg3_unchanged", 64'h0000_0000_0000_0008);
    rd_gather = 1'b1;
    rd_idx = 64'h0000_0000_4101_0343;
    tick();
    check("gather", rd_data, 64'h0000_0000_020A_0800);
    rd_gather = 1'b0;

    // Write and beat in the same cycle; lane 0 saturates.
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 64'h0000_FFFF_0000_FFFF;
    beat(64'h0505_0505_0505_0505, n);
    read_full(6'd5, "reg5_sat", 64'h0000_FFFF_0000_FFFF);
`ifdef HIST_SAT_FLAG_EN
    check("sat_set", sat_flag, 1'b1);
`endif
    clr_start = 1'b1;
    accum_valid = 1'b1;
    #1;
    check("clr_prio_ready", accum_ready, 1'b0);
    tick();
    clr_start = 1'b0;
    accum_valid = 1'b0;
    wait_idle("cmd_clear", n);
    check("cmd_clear_len", 64'(n), 64'd64);
    read_full(6'd5, "reg5_cleared", 64'd0);
`ifdef HIST_SAT_FLAG_EN
    check("sat_cleared", sat_flag, 1'b0);
`endif

    // Random traffic, bins concentrated on a few registers.
    for (int c = 0; c < 700; c++) begin
      accum_valid = ($urandom_range(0, 2) == 0);
      for (int s = 0; s < int'(NS); s++)
        accum_data[s*SW +: SW] = 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
      wr_en = ($urandom_range(0, 11) == 0);
      wr_addr = 6'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom};
      clr_start = ($urandom_range(0, 149) == 0);
      rd_gather = 1'($urandom_range(0, 1));
      rd_addr = 6'($urandom_range(0, 7));
      rd_idx = {$urandom, $urandom};
      tick();
    end
    accum_valid = 1'b0; wr_en = 1'b0; clr_start = 1'b0; rd_gather = 1'b0;
    wait_idle("random_drain", n);

    // Reset in the middle of a beat.
    accum_valid = 1'b1;
    accum_data  = 64'h0707_0707_0707_0707;
    tick();
    accum_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_wr_drop", wr_drop, 1'b0);
    check("rst_ready", accum_ready, 1'b0);
    check("rst_rd_data", rd_data, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle("reset2_clear", n);
    check("reset2_clear_len", 64'(n), 64'd64);
    for (int r = 0; r < int'(NR); r++) read_full(6'(r), "reset2_zero", 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
